dram_traffic_gen: RTL

Synthesizable, parametrised traffic generator and read-back checker for the DRAM memory controller. It sweeps a configurable rank/bank/row/column window with a write pass, then a read pass, and issues commands on the controller's 36-bit command port, throttled by per-bank readiness. Read data is checked in order against a recomputable address-derived pattern. It reports error, cycle and command counts, so bandwidth utilisation and latency are measured in silicon or emulation instead of only in a testbench.

---
 rtl/dram_traffic_gen_if.sv | 21 ++
 rtl/dram_traffic_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dram_traffic_gen_if.sv
// Command/data port between the DRAM traffic generator and the controller.
// The generator drives commands and write data; the controller answers.
interface dram_traffic_gen_if #(
   parameter int DATA_W = 128
);
   logic [35:0]       command;
   logic              valid;
   logic [DATA_W-1:0] write_data;
   logic [7:0]        ba_cmd_pm;
   logic [DATA_W-1:0] read_data;
   logic              read_data_valid;

   modport master (
      output command, valid, write_data,
      input  ba_cmd_pm, read_data, read_data_valid
   );
   modport slave (
      input  command, valid, write_data,
      output ba_cmd_pm, read_data, read_data_valid
   );
endinterface

// File: rtl/dram_traffic_gen.sv
// DRAM traffic generator: write pass, read pass, in-order read-back check.
// Reports error, cycle and command counts for bandwidth measurement.
module dram_traffic_gen #(
   parameter int          DATA_W        = 128,
   parameter int          NUM_BANKS     = 1,
   parameter int          NUM_ROWS      = 128,
   parameter int          NUM_COLS      = 880,
   parameter int          COL_STEP      = 8,
   parameter logic [2:0]  RANK          = 3'd0,
   parameter logic [31:0] SEED          = 32'h5A5A_0000,
   parameter int          DRAIN_TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               power_on_rst,
   input  logic               start,
   input  logic [1:0]         mode,
   dram_traffic_gen_if.master bus,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [31:0]        error_count,
   output logic [31:0]        cycle_count,
   output logic [31:0]        write_cmd_count,
   output logic [31:0]        read_cmd_count,
   output logic [31:0]        first_err_addr
);

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE
   } state_e;

   typedef struct packed {
      logic [2:0]  b;
      logic [12:0] r;
      logic [9:0]  c;
   } addr_t;

   localparam logic [2:0]  LAST_B = 3'(NUM_BANKS - 1);
   localparam logic [12:0] LAST_R = 13'(NUM_ROWS - 1);
   localparam logic [9:0]  LAST_C = 10'(NUM_COLS - COL_STEP);
   localparam logic [9:0]  STEP   = 10'(COL_STEP);
   localparam logic [31:0] TMO    = 32'(DRAIN_TIMEOUT - 1);
   localparam int          LANES  = DATA_W / 32;

   // il selects bank-innermost order; otherwise column is innermost
   function automatic addr_t adv(input addr_t a, input logic il);
      addr_t n;
      n = a;
      if (il) begin
         if (a.b != LAST_B) n.b = a.b + 3'd1;
         else begin
            n.b = '0;
            if (a.c != LAST_C) n.c = a.c + STEP;
            else begin
               n.c = '0;
               n.r = a.r + 13'd1;
            end
         end
      end else begin
         if (a.c != LAST_C) n.c = a.c + STEP;
         else begin
            n.c = '0;
            if (a.r != LAST_R) n.r = a.r + 13'd1;
            else begin
               n.r = '0;
               n.b = a.b + 3'd1;
            end
         end
      end
      return n;
   endfunction

   function automatic logic [DATA_W-1:0] pat(input addr_t a);
      logic [DATA_W-1:0] p;
      logic [31:0]       w;
      w = {6'd0, a} ^ SEED;
      p = '0;
      for (int k = 0; k < LANES; k++) p[32*k +: 32] = w + 32'(k);
      return p;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] x);
      return (x == '1) ? x : x + 32'd1;
   endfunction

   state_e            state_q, state_d;
   logic [1:0]        mode_q;
   addr_t             a_q, e_q;
   logic              end_q;
   logic [35:0]       cmd_q;
   logic              vld_q;
   logic [DATA_W-1:0] wd_q;
   logic [31:0]       wcnt_q, rcnt_q, ret_q, err_q, err_d;
   logic [31:0]       cyc_q, fea_q, idle_q;
   logic [31:0]       err_inc;
   logic [32:0]       err_sum;

   logic il, run, issue, last, rd_hit, spur, mism, drained, tmo, go;

   assign il      = (mode_q == 2'd1);
   assign run     = state_q inside {S_WRITE, S_READ, S_DRAIN};
   assign issue   = (state_q == S_WRITE || state_q == S_READ) && !end_q
                    && bus.ba_cmd_pm[a_q.b];
   assign last    = (a_q.b == LAST_B) && (a_q.r == LAST_R) && (a_q.c == LAST_C);
   assign rd_hit  = run && bus.read_data_valid && (ret_q != rcnt_q);
   assign spur    = run && bus.read_data_valid && (ret_q == rcnt_q);
   assign mism    = rd_hit && (bus.read_data != pat(e_q));
   assign drained = (ret_q + 32'(rd_hit)) == rcnt_q;
   assign tmo     = (state_q == S_DRAIN) && !rd_hit && (idle_q == TMO);
   assign go      = start && (state_q == S_IDLE || state_q == S_DONE);

   always_ff @(posedge clk or posedge power_on_rst) begin
      if (power_on_rst) state_q <= S_IDLE;
      else              state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = (mode == 2'd3) ? S_READ : S_WRITE;
         S_WRITE: if (end_q) state_d = (mode_q == 2'd2) ? S_DONE : S_READ;
         S_READ:  if (end_q) state_d = S_DRAIN;
         S_DRAIN: if (drained || tmo) state_d = S_DONE;
         S_DONE:  if (start) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy            = run;
      done            = (state_q == S_DONE);
      pass            = (state_q == S_DONE) && (err_q == '0);
      error_count     = err_q;
      cycle_count     = cyc_q;
      write_cmd_count = wcnt_q;
      read_cmd_count  = rcnt_q;
      first_err_addr  = fea_q;
   end

   assign bus.command    = cmd_q;
   assign bus.valid      = vld_q;
   assign bus.write_data = wd_q;

   // a timeout charges every still-missing return at once
   always_comb begin
      err_inc = 32'(mism | spur);
      if (tmo) err_inc = rcnt_q - ret_q;
      err_sum = {1'b0, err_q} + {1'b0, err_inc};
      err_d   = err_sum[32] ? '1 : err_sum[31:0];
   end

   always_ff @(posedge clk or posedge power_on_rst) begin
      if (power_on_rst) begin
         mode_q <= '0;
         a_q    <= '0;
         e_q    <= '0;
         end_q  <= 1'b0;
         cmd_q  <= '0;
         vld_q  <= 1'b0;
         wd_q   <= '0;
         wcnt_q <= '0;
         rcnt_q <= '0;
         ret_q  <= '0;
         err_q  <= '0;
         cyc_q  <= '0;
         fea_q  <= '0;
         idle_q <= '0;
      end else begin
         vld_q <= issue;
         cmd_q <= issue ? {RANK, {1'b0, state_q == S_READ}, 1'b0, a_q.r,
                           1'b0, 1'b1, 1'b0, 1'b0, a_q.c, a_q.b} : '0;
         wd_q  <= (issue && state_q == S_WRITE) ? pat(a_q) : '0;
         end_q <= issue && last;
         if (go) begin
            if (state_q == S_IDLE) mode_q <= mode;
            a_q    <= '0;
            e_q    <= '0;
            wcnt_q <= '0;
            rcnt_q <= '0;
            ret_q  <= '0;
            err_q  <= '0;
            cyc_q  <= '0;
            fea_q  <= '0;
            idle_q <= '0;
         end else begin
            if (issue) begin
               a_q <= last ? '0 : adv(a_q, il);
               if (state_q == S_WRITE) wcnt_q <= sat_inc(wcnt_q);
               else                    rcnt_q <= sat_inc(rcnt_q);
            end
            if (rd_hit) begin
               ret_q <= ret_q + 32'd1;
               e_q   <= adv(e_q, il);
            end
            err_q <= err_d;
            if (mism && err_q == '0) fea_q <= {3'b0, e_q, 3'b0};
            if (run) cyc_q <= sat_inc(cyc_q);
            idle_q <= (state_q == S_DRAIN && !rd_hit) ? idle_q + 32'd1 : '0;
         end
      end
   end

endmodule
